// File: rtl/block_a20_pkg.sv
// Shared constants, types, basis table and reference encoder for the (20,A) UCI block code.
package block_a20_pkg;

  localparam int A20_NUM_SYMBOLS = 20;
  localparam int A20_MAX_A       = 13;

  typedef logic [12:0] a20_info_t;
  typedef logic [19:0] a20_cw_t;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_CALC    = 2'd1,
    ST_SEND    = 2'd2
  } a20_state_e;

  // Row i holds M[i][0..12] with M[i][0] in the MSB, so M[i][n] is bit 12-n.
  localparam a20_info_t A20_BASIS [0:19] = '{
    13'b1100000000110, 13'b1110000001110, 13'b1001001011111, 13'b1011000010111,
    13'b1111000100111, 13'b1100101110111, 13'b1010101011111, 13'b1001100110111,
    13'b1101100101111, 13'b1011101001111, 13'b1010011101111, 13'b1110011010111,
    13'b1001010111111, 13'b1101010101111, 13'b1000110100101, 13'b1100111101101,
    13'b1110111001011, 13'b1001110010011, 13'b1101111100000, 13'b1000011000000
  };

  function automatic a20_cw_t a20_encode(input a20_info_t info, input logic [3:0] a);
    a20_cw_t cw;
    cw = '0;
    for (int i = 0; i < A20_NUM_SYMBOLS; i++) begin
      for (int n = 0; n < A20_MAX_A; n++) begin
        if (n < int'(a)) cw[i] = cw[i] ^ (info[n] & A20_BASIS[i][12-n]);
      end
    end
    return cw;
  endfunction

endpackage

// File: rtl/block_encode_a20_if.sv
// Stream/control bundle of block_encode_a20: 1-bit info stream in, coded stream out.
interface block_encode_a20_if #(
  parameter int DATA_WIDTH = 8
);
  logic [7:0]            code_length;
  logic                  code_length_valid;
  logic                  s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic                  s_axis_tlast;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  logic                  len_err;

  modport slave (
    input  code_length, code_length_valid, s_axis_tdata, s_axis_tvalid, s_axis_tlast,
           m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, len_err
  );

  modport master (
    output code_length, code_length_valid, s_axis_tdata, s_axis_tvalid, s_axis_tlast,
           m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, len_err
  );
endinterface

// File: rtl/a20_codeword_calc.sv
// Combinational (20,A) codeword generator: info bits and A in, 20-bit codeword out.
module a20_codeword_calc
  import block_a20_pkg::*;
(
  input  a20_info_t  info_i,
  input  logic [3:0] a_i,
  output a20_cw_t    cw_o
);
  assign cw_o = a20_encode(info_i, a_i);
endmodule

// File: rtl/block_encode_a20.sv
// (20,A) UCI block encoder: collects A info bits, computes the codeword, streams 20 coded beats.
// Optional macro BLOCK_ENC_A20_SOFT_OUT_EN: emit BPSK soft values (+/-SOFT_MAG) instead of hard bits.
module block_encode_a20
  import block_a20_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_SYMBOLS = 20,
  parameter int MAX_A       = 13,
  parameter int SOFT_MAG    = 64
) (
  input  logic              clk,
  input  logic              s_axis_areset,
  block_encode_a20_if.slave bus
);

  if (NUM_SYMBOLS != A20_NUM_SYMBOLS || MAX_A != A20_MAX_A ||
      SOFT_MAG <= 0 || SOFT_MAG >= (1 << (DATA_WIDTH - 1))) begin : g_bad_cfg
    $error("block_encode_a20: unsupported parameter set");
  end

  localparam int LAST_IDX = NUM_SYMBOLS - 1;

  a20_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] a_q, a_d;
  logic [4:0] idx_q, idx_d;
  a20_info_t  info_q, info_d;
  a20_cw_t    cw_q, cw_calc;
  logic       rdy_q;
  logic       len_err_q, len_err_d;

  logic       s_hs, m_hs, send_last, a_load;
  logic [3:0] a_eff;
  logic [4:0] cnt_inc;

  function automatic logic [DATA_WIDTH-1:0] map_bit(input logic b);
`ifdef BLOCK_ENC_A20_SOFT_OUT_EN
    logic signed [DATA_WIDTH-1:0] mag;
    mag = DATA_WIDTH'(SOFT_MAG);
    return b ? -mag : mag;
`else
    return {{(DATA_WIDTH-1){1'b0}}, b};
`endif
  endfunction

  assign s_hs      = rdy_q && bus.s_axis_tvalid;
  assign m_hs      = (state_q == ST_SEND) && bus.m_axis_tready;
  assign send_last = m_hs && (idx_q == 5'(LAST_IDX));
  // A may only change at a codeword boundary; a same-cycle strobe applies to the first beat.
  assign a_load    = (state_q == ST_COLLECT) && (cnt_q == 4'd0) && bus.code_length_valid &&
                     (bus.code_length != 8'd0) && (bus.code_length <= 8'(MAX_A));
  assign a_eff     = a_load ? bus.code_length[3:0] : a_q;
  assign cnt_inc   = {1'b0, cnt_q} + 5'd1;

  a20_codeword_calc u_calc (
    .info_i (info_q),
    .a_i    (a_q),
    .cw_o   (cw_calc)
  );

  always_ff @(posedge clk) begin
    if (s_axis_areset) begin
      state_q   <= ST_COLLECT;
      cnt_q     <= 4'd0;
      a_q       <= 4'(A20_MAX_A);
      idx_q     <= 5'd0;
      info_q    <= '0;
      rdy_q     <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      idx_q     <= idx_d;
      info_q    <= info_d;
      rdy_q     <= (state_d == ST_COLLECT);
      len_err_q <= len_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_CALC) cw_q <= cw_calc;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (s_hs && bus.s_axis_tlast) state_d = ST_CALC;
      ST_CALC:    state_d = ST_SEND;
      ST_SEND:    if (send_last) state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    a_d       = a_q;
    idx_d     = idx_q;
    info_d    = info_q;
    len_err_d = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        a_d = a_eff;
        if (s_hs) begin
          // The count saturates at A, so surplus beats are dropped and tlast still sees cnt+1 != A.
          if (cnt_q < a_eff) begin
            info_d[cnt_q] = bus.s_axis_tdata;
            cnt_d         = cnt_inc[3:0];
          end
          if (bus.s_axis_tlast) len_err_d = (cnt_inc != {1'b0, a_eff});
        end
      end
      ST_SEND: begin
        if (send_last) begin
          idx_d  = 5'd0;
          cnt_d  = 4'd0;
          info_d = '0;
        end else if (m_hs) begin
          idx_d = idx_q + 5'd1;
        end
      end
      default: ;
    endcase
  end

  assign bus.s_axis_tready = rdy_q;
  assign bus.m_axis_tvalid = (state_q == ST_SEND);
  assign bus.m_axis_tlast  = (state_q == ST_SEND) && (idx_q == 5'(LAST_IDX));
  assign bus.m_axis_tdata  = (state_q == ST_SEND) ? map_bit(cw_q[idx_q]) : '0;
  assign bus.len_err       = len_err_q;

endmodule

// File: tb/tb_block_encode_a20.sv
// Self-checking bench for block_encode_a20: vector table, hand sequences and random codewords.
module tb_block_encode_a20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  block_encode_a20_if #(.DATA_WIDTH(8)) bus ();

  block_encode_a20 #(
    .DATA_WIDTH(8), .NUM_SYMBOLS(20), .MAX_A(13), .SOFT_MAG(64)
  ) dut (
    .clk           (clk),
    .s_axis_areset (rst),
    .bus           (bus)
  );

  int checks = 0;
  int errors = 0;
  int lerr_cnt = 0;

  always @(negedge clk) if (bus.len_err === 1'b1) lerr_cnt <= lerr_cnt + 1;

  // Basis rows M[i][0..12], leftmost character is M[i][0].
  string M_ROWS [20] = '{
    "1100000000110", "1110000001110", "1001001011111", "1011000010111",
    "1111000100111", "1100101110111", "1010101011111", "1001100110111",
    "1101100101111", "1011101001111", "1010011101111", "1110011010111",
    "1001010111111", "1101010101111", "1000110100101", "1100111101101",
    "1110111001011", "1001110010011", "1101111100000", "1000011000000"
  };

  function automatic logic [19:0] model_enc(input logic [12:0] info, input int a);
    logic [19:0] cw;
    cw = '0;
    for (int n = 0; n < a; n++)
      if (info[n])
        for (int i = 0; i < 20; i++)
          if (M_ROWS[i][n] == 8'h31) cw[i] = ~cw[i];
    return cw;
  endfunction

  // Only the first min(nb, A) beats carry information; the rest are zero or discarded.
  function automatic logic [19:0] exp_of(input int a, input logic [15:0] bits, input int nb);
    logic [12:0] info;
    int lim;
    info = '0;
    lim = (nb < a) ? nb : a;
    for (int n = 0; n < lim; n++) info[n] = bits[n];
    return model_enc(info, a);
  endfunction

  function automatic logic beat_bit(input logic [7:0] d);
`ifdef BLOCK_ENC_A20_SOFT_OUT_EN
    return d == 8'hC0;
`else
    return d[0];
`endif
  endfunction

  function automatic logic beat_ok(input logic [7:0] d);
`ifdef BLOCK_ENC_A20_SOFT_OUT_EN
    return (d == 8'h40) || (d == 8'hC0);
`else
    return d <= 8'd1;
`endif
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_info(input logic [15:0] bits, input int nb, input int cl, input bit strobe);
    int t;
    for (int k = 0; k < nb; k++) begin
      bus.s_axis_tvalid     = 1'b1;
      bus.s_axis_tdata      = bits[k];
      bus.s_axis_tlast      = (k == nb - 1);
      bus.code_length       = 8'(cl);
      bus.code_length_valid = strobe && (k == 0);
      t = 0;
      while (!bus.s_axis_tready && t < 200) begin
        step();
        t++;
      end
      if (t >= 200) chk("s_ready_timeout", 0, 1);
      step();
    end
    bus.s_axis_tvalid     = 1'b0;
    bus.s_axis_tlast      = 1'b0;
    bus.code_length_valid = 1'b0;
  endtask

  task automatic recv(input int mode, input int cl_send, output logic [19:0] cw);
    int beats, cyc, phase, badlast, badstall, badrdy, badval;
    logic r, pstall, pl;
    logic [7:0] pd;
    beats = 0; cyc = 0; phase = 0; badlast = 0; badstall = 0; badrdy = 0; badval = 0;
    pstall = 1'b0; pl = 1'b0; pd = '0; cw = '0;
    while (beats < 20 && cyc < 3000) begin
      case (mode)
        1:       r = ((phase % 30) < 10);
        2:       r = 1'($urandom_range(0, 1));
        default: r = 1'b1;
      endcase
      bus.m_axis_tready     = r;
      bus.code_length       = 8'(cl_send);
      bus.code_length_valid = (cl_send != 0) && (beats == 5);
      if (pstall && (!bus.m_axis_tvalid || bus.m_axis_tdata != pd || bus.m_axis_tlast != pl))
        badstall++;
      else if (beats > 0 && !bus.m_axis_tvalid)
        badstall++;
      if (bus.m_axis_tvalid) begin
        if (bus.s_axis_tready) badrdy++;
        if (!beat_ok(bus.m_axis_tdata)) badval++;
        if (bus.m_axis_tlast != (beats == 19)) badlast++;
        if (r) begin
          cw[beats] = beat_bit(bus.m_axis_tdata);
          beats++;
        end
        pstall = !r;
        pd     = bus.m_axis_tdata;
        pl     = bus.m_axis_tlast;
      end else begin
        pstall = 1'b0;
      end
      phase++;
      cyc++;
      step();
    end
    bus.m_axis_tready     = 1'b0;
    bus.code_length_valid = 1'b0;
    chk("out_beats", beats, 20);
    chk("tlast_pos", badlast, 0);
    chk("stall_stable", badstall, 0);
    chk("s_ready_in_send", badrdy, 0);
    chk("tdata_value", badval, 0);
  endtask

  task automatic run_vec(input int a, input logic [15:0] bits, input int nb, input bit strobe,
                         input int mode, input int cl_send, input logic [19:0] exp_cw,
                         input int exp_err, input bit chk_lat, output logic [19:0] got);
    int base;
    base = lerr_cnt;
    send_info(bits, nb, a, strobe);
    if (chk_lat) begin
      chk("lat_calc_tvalid", bus.m_axis_tvalid, 0);
      step();
      chk("lat_send_tvalid", bus.m_axis_tvalid, 1);
    end
    recv(mode, cl_send, got);
    chk("codeword", got, exp_cw);
    chk("len_err_pulses", lerr_cnt - base, exp_err);
  endtask

  typedef struct {
    int          a;
    logic [15:0] bits;
    int          nb;
    int          mode;
    logic [19:0] exp_cw;
    int          exp_err;
  } vec_t;

  vec_t vt [8];

  initial begin
    logic [19:0] got, gx, gy, gxy;
    logic [15:0] x, y, bits;
    int a, nb, t;

    bus.code_length = 8'd0; bus.code_length_valid = 1'b0;
    bus.s_axis_tdata = 1'b0; bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
    bus.m_axis_tready = 1'b0;

    vt[0] = '{1,  16'h0001, 1,  0, 20'hFFFFF, 1'b0};
    vt[1] = '{13, 16'h0000, 13, 0, 20'h00000, 0};
    vt[2] = '{13, 16'h1FFF, 13, 0, exp_of(13, 16'h1FFF, 13), 0};
    vt[3] = '{5,  16'h001F, 3,  0, exp_of(5, 16'h0007, 5), 1};
    vt[4] = '{5,  16'h0075, 7,  0, exp_of(5, 16'h0015, 5), 1};
    vt[5] = '{13, 16'h0A5A, 13, 1, exp_of(13, 16'h0A5A, 13), 0};
    vt[6] = '{7,  16'h0055, 7,  2, exp_of(7, 16'h0055, 7), 0};
    vt[7] = '{2,  16'h0002, 2,  1, exp_of(2, 16'h0002, 2), 0};

    rst = 1'b1;
    repeat (3) step();
    chk("rst_s_tready", bus.s_axis_tready, 0);
    chk("rst_m_tvalid", bus.m_axis_tvalid, 0);
    chk("rst_m_tdata", bus.m_axis_tdata, 0);
    chk("rst_m_tlast", bus.m_axis_tlast, 0);
    chk("rst_len_err", bus.len_err, 0);
    rst = 1'b0;
    step();
    chk("rdy_after_rst", bus.s_axis_tready, 1);

    // A reset value of 13: a 13-beat codeword with no strobe must encode cleanly.
    run_vec(13, 16'h1234, 13, 1'b0, 0, 0, exp_of(13, 16'h1234, 13), 0, 1'b0, got);

    foreach (vt[i])
      run_vec(vt[i].a, vt[i].bits, vt[i].nb, 1'b1, vt[i].mode, 0, vt[i].exp_cw,
              vt[i].exp_err, (i == 0), got);

    // Linearity over GF(2) at A=13.
    x = 16'($urandom) & 16'h1FFF;
    y = 16'($urandom) & 16'h1FFF;
    run_vec(13, x, 13, 1'b1, 0, 0, exp_of(13, x, 13), 0, 1'b0, gx);
    run_vec(13, y, 13, 1'b1, 2, 0, exp_of(13, y, 13), 0, 1'b0, gy);
    run_vec(13, x ^ y, 13, 1'b1, 0, 0, exp_of(13, x ^ y, 13), 0, 1'b0, gxy);
    chk("linearity", gx ^ gy, gxy);

    // Illegal lengths while idle and any length during SEND leave A=4 in place.
    run_vec(4, 16'h000B, 4, 1'b1, 0, 0, exp_of(4, 16'h000B, 4), 0, 1'b0, got);
    bus.code_length = 8'd0;  bus.code_length_valid = 1'b1; step();
    bus.code_length = 8'd14; step();
    bus.code_length_valid = 1'b0;
    run_vec(4, 16'h0006, 4, 1'b0, 0, 3, exp_of(4, 16'h0006, 4), 0, 1'b0, got);
    run_vec(4, 16'h0009, 4, 1'b0, 2, 0, exp_of(4, 16'h0009, 4), 0, 1'b0, got);

    // Reset in the middle of SEND aborts the codeword and restores A=13.
    send_info(16'h0025, 6, 6, 1'b1);
    t = 0;
    while (!bus.m_axis_tvalid && t < 10) begin
      step();
      t++;
    end
    chk("pre_rst_tvalid", bus.m_axis_tvalid, 1);
    bus.m_axis_tready = 1'b1;
    repeat (5) step();
    rst = 1'b1;
    step();
    chk("midrst_tvalid", bus.m_axis_tvalid, 0);
    chk("midrst_s_tready", bus.s_axis_tready, 0);
    chk("midrst_tdata", bus.m_axis_tdata, 0);
    step();
    rst = 1'b0;
    bus.m_axis_tready = 1'b0;
    step();
    chk("midrst_release_rdy", bus.s_axis_tready, 1);
    chk("midrst_tvalid_idle", bus.m_axis_tvalid, 0);
    run_vec(13, 16'h0F0F, 13, 1'b0, 0, 0, exp_of(13, 16'h0F0F, 13), 0, 1'b0, got);

    for (int k = 0; k < 20; k++) begin
      a    = $urandom_range(1, 13);
      nb   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : a;
      bits = 16'($urandom);
      run_vec(a, bits, nb, 1'b1, $urandom_range(0, 2), 0, exp_of(a, bits, nb),
              int'(nb != a), 1'b0, got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
